// File: rtl/md_sched_pkg.sv
// Shared definitions for the mult/div scheduler and the decode stage.
package md_sched_pkg;

   // Scheduler state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } md_state_t;

   // Exception reporting defaults
   localparam int RSTATUS_REG   = 30;
   localparam int EXC_MULT_CODE = 4;
   localparam int EXC_DIV_CODE  = 5;

   // Instruction fields that select a mult/div (shared with decode)
   localparam logic [4:0] OPC_ALU   = 5'b00000;
   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;

   function automatic logic is_mult_op(input logic [4:0] opcode, input logic [4:0] aluop);
      return (opcode == OPC_ALU) && (aluop == ALUOP_MUL);
   endfunction

   function automatic logic is_div_op(input logic [4:0] opcode, input logic [4:0] aluop);
      return (opcode == OPC_ALU) && (aluop == ALUOP_DIV);
   endfunction

endpackage

// File: rtl/multdiv_sched.sv
// Scheduler for the shared mult/div unit: launches one op at a time, tracks
// its destination for hazard stalls, and merges its result onto the single
// regfile write port behind the pipeline's own writeback.
module multdiv_sched
   import md_sched_pkg::*;
#(
   parameter int RSTATUS  = RSTATUS_REG,
   parameter int EXC_MULT = EXC_MULT_CODE,
   parameter int EXC_DIV  = EXC_DIV_CODE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_mult,
   input  logic        issue_div,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   input  logic [4:0]  dec_rs,
   input  logic [4:0]  dec_rt,
   input  logic [4:0]  dec_rd,
   input  logic        dec_we,
   input  logic        mw_we,
   input  logic [4:0]  mw_rd,
   input  logic [31:0] mw_data,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        stall,
   output logic        busy
);

   localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS);

   md_state_t   state_reg, state_next;
   logic [4:0]  pend_rd_reg;
   logic        pend_is_div_reg;
   logic [31:0] op_a_reg, op_b_reg;
   logic [31:0] buf_data_reg;
   logic [4:0]  buf_rd_reg;
   logic        start_mult_reg, start_div_reg;

   logic issue_any, in_run, in_done, drain, accept, capture, raw_waw;

   // Decode of the current cycle's events from registered state and inputs
   always_comb begin
      issue_any = issue_mult | issue_div;
      in_run    = (state_reg == ST_RUN);
      in_done   = (state_reg == ST_DONE);
      drain     = in_done & ~mw_we;
      accept    = issue_any & ((state_reg == ST_IDLE) | drain);
      capture   = in_run & md_resultRDY;
   end

   // Next-state logic; a drain with a waiting issue chains straight into RUN
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (issue_any)    state_next = ST_RUN;
         ST_RUN:  if (md_resultRDY) state_next = ST_DONE;
         ST_DONE: if (drain)        state_next = issue_any ? ST_RUN : ST_IDLE;
         default:                   state_next = ST_IDLE;
      endcase
   end

   // State, scoreboard, operand latches, result buffer and start pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         pend_rd_reg     <= '0;
         pend_is_div_reg <= 1'b0;
         op_a_reg        <= '0;
         op_b_reg        <= '0;
         buf_data_reg    <= '0;
         buf_rd_reg      <= '0;
         start_mult_reg  <= 1'b0;
         start_div_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         start_mult_reg <= accept & ~issue_div;
         start_div_reg  <= accept & issue_div;
         if (accept) begin
            pend_rd_reg     <= issue_rd;
            pend_is_div_reg <= issue_div;
            op_a_reg        <= issue_a;
            op_b_reg        <= issue_b;
         end
         if (capture) begin
            if (md_exception) begin
               buf_data_reg <= pend_is_div_reg ? 32'(EXC_DIV) : 32'(EXC_MULT);
               buf_rd_reg   <= RSTATUS_IDX;
            end else begin
               buf_data_reg <= md_result;
               buf_rd_reg   <= pend_rd_reg;
            end
         end
      end
   end

   // Write-port mux: pipeline first, buffered result only in free cycles
   always_comb begin
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      if (mw_we) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = mw_rd;
         data_writeReg    = mw_data;
      end else if (drain) begin
         ctrl_writeEnable = (buf_rd_reg != 5'd0);
         ctrl_writeReg    = buf_rd_reg;
         data_writeReg    = buf_data_reg;
      end
   end

   // Hazard stall; RSTATUS is treated as pending because an exception may land there
   always_comb begin
      raw_waw = ((dec_rs == pend_rd_reg) && (pend_rd_reg != 5'd0))
              | ((dec_rt == pend_rd_reg) && (pend_rd_reg != 5'd0))
              | (dec_rs == RSTATUS_IDX) | (dec_rt == RSTATUS_IDX)
              | (dec_we && (dec_rd == pend_rd_reg));
      stall   = (in_run | (in_done & ~drain)) & (raw_waw | issue_any);
   end

   assign md_ctrl_mult = start_mult_reg;
   assign md_ctrl_div  = start_div_reg;
   assign md_operandA  = op_a_reg;
   assign md_operandB  = op_b_reg;
   assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_multdiv_sched.sv
// Self-checking bench for multdiv_sched: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a transaction model.
module tb_multdiv_sched;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_mult, issue_div;
   logic [4:0]  issue_rd;
   logic [31:0] issue_a, issue_b;
   logic        md_ctrl_mult, md_ctrl_div;
   logic [31:0] md_operandA, md_operandB;
   logic [31:0] md_result;
   logic        md_exception, md_resultRDY;
   logic [4:0]  dec_rs, dec_rt, dec_rd;
   logic        dec_we;
   logic        mw_we;
   logic [4:0]  mw_rd;
   logic [31:0] mw_data;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        stall, busy;

   multdiv_sched dut (
      .clock(clock), .reset(reset),
      .issue_mult(issue_mult), .issue_div(issue_div), .issue_rd(issue_rd),
      .issue_a(issue_a), .issue_b(issue_b),
      .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_we(dec_we),
      .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .stall(stall), .busy(busy)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stimulus requested for the next cycle
   bit          s_mult, s_div, s_dwe, s_mwe, s_spur, s_reset;
   logic [4:0]  s_rd, s_rs, s_rt, s_drd, s_mrd;
   logic [31:0] s_a, s_b, s_mdata;

   // Transaction model: one outstanding op, optionally with its result known
   bit          m_live, m_res, m_isdiv, m_pm, m_pd;
   logic [4:0]  m_rd, m_wdest;
   logic [31:0] m_a, m_b, m_wdata;

   // Emulated mult/div unit answering the start pulse after a latency
   bit          emu_on, emu_div;
   int          emu_cnt, emu_lat, emu_rdy_cyc;
   logic [31:0] emu_a, emu_b;

   // Observations
   int          cyc;
   bit          do_check, obs_stall, obs_pulse;
   int          pulse_cnt;
   logic [4:0]  wlog_reg[$];
   logic [31:0] wlog_data[$];
   int          wlog_cyc[$];

   task automatic md_compute(input bit isdiv, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output bit exc);
      longint p;
      if (isdiv) begin
         exc = (b == 0) || (a == 32'h80000000 && b == 32'hffffffff);
         r   = exc ? 32'h0 : 32'($signed(a) / $signed(b));
      end else begin
         p   = longint'($signed(a)) * longint'($signed(b));
         r   = p[31:0];
         exc = (p != longint'($signed(p[31:0])));
      end
   endtask

   task automatic clear_stim();
      s_mult = 0; s_div = 0; s_dwe = 0; s_mwe = 0; s_spur = 0; s_reset = 0;
      s_rd = 0; s_rs = 0; s_rt = 0; s_drd = 0; s_mrd = 0;
      s_a = 0; s_b = 0; s_mdata = 0;
   endtask

   task automatic clear_log();
      wlog_reg.delete(); wlog_data.delete(); wlog_cyc.delete();
      pulse_cnt = 0;
   endtask

   function automatic logic [4:0] pick_reg();
      return ($urandom_range(0, 9) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
   endfunction

   // One clock cycle: drive, check away from the edge, then advance the model
   task automatic cycle();
      logic [31:0] r;
      bit          e, drain, haz, exp_we, exp_stall;
      reset = s_reset;
      issue_mult = s_mult; issue_div = s_div; issue_rd = s_rd; issue_a = s_a; issue_b = s_b;
      dec_rs = s_rs; dec_rt = s_rt; dec_rd = s_drd; dec_we = s_dwe;
      mw_we = s_mwe; mw_rd = s_mrd; mw_data = s_mdata;
      md_resultRDY = 0; md_result = 0; md_exception = 0;
      if (emu_on) begin
         if (emu_cnt == 0) begin
            md_compute(emu_div, emu_a, emu_b, r, e);
            md_resultRDY = 1; md_result = r; md_exception = e;
            emu_on = 0; emu_rdy_cyc = cyc;
         end else emu_cnt--;
      end else if (s_spur) begin
         md_resultRDY = 1; md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
      end
      if (m_pm || m_pd) begin
         emu_on = 1; emu_div = m_pd; emu_a = m_a; emu_b = m_b;
         emu_cnt = (emu_lat < 0) ? $urandom_range(0, 3) : emu_lat;
      end
      #3;
      drain = m_live && m_res && !mw_we;
      haz = (dec_rs != 0 && dec_rs == m_rd) || (dec_rt != 0 && dec_rt == m_rd) ||
            dec_rs == 30 || dec_rt == 30 || (dec_we && dec_rd == m_rd);
      exp_stall = m_live && !drain && (haz || issue_mult || issue_div);
      exp_we = mw_we ? 1'b1 : (drain && m_wdest != 0);
      if (do_check) begin
         chk("write_en", ctrl_writeEnable, exp_we);
         if (exp_we) begin
            chk("write_reg",  ctrl_writeReg, mw_we ? mw_rd : m_wdest);
            chk("write_data", data_writeReg, mw_we ? mw_data : m_wdata);
         end
         chk("stall", stall, exp_stall);
         chk("busy", busy, m_live);
         chk("ctrl_mult", md_ctrl_mult, m_pm);
         chk("ctrl_div", md_ctrl_div, m_pd);
         if (m_live && !m_res) begin
            chk("operandA", md_operandA, m_a);
            chk("operandB", md_operandB, m_b);
         end
      end
      if (ctrl_writeEnable) begin
         wlog_reg.push_back(ctrl_writeReg); wlog_data.push_back(data_writeReg); wlog_cyc.push_back(cyc);
      end
      if (md_ctrl_mult || md_ctrl_div) pulse_cnt++;
      obs_stall = stall; obs_pulse = md_ctrl_mult;
      @(posedge clock);
      if (reset) begin
         m_live = 0; m_res = 0; m_pm = 0; m_pd = 0;
      end else begin
         m_pm = 0; m_pd = 0;
         if ((issue_mult || issue_div) && (!m_live || drain)) begin
            m_live = 1; m_res = 0; m_rd = issue_rd; m_isdiv = issue_div;
            m_a = issue_a; m_b = issue_b; m_pm = !issue_div; m_pd = issue_div;
         end else if (drain) begin
            m_live = 0; m_res = 0;
         end else if (m_live && !m_res && md_resultRDY) begin
            m_res   = 1;
            m_wdest = md_exception ? 5'd30 : m_rd;
            m_wdata = md_exception ? (m_isdiv ? 32'd5 : 32'd4) : md_result;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic issue_op(input bit isdiv, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
      s_mult = !isdiv; s_div = isdiv; s_rd = rd; s_a = a; s_b = b;
      cycle();
      s_mult = 0; s_div = 0;
   endtask

   initial begin
      bit found, prev_stall;
      cyc = 0; do_check = 0; emu_on = 0; emu_lat = -1; emu_rdy_cyc = 0;
      m_live = 0; m_res = 0; m_pm = 0; m_pd = 0; m_rd = 0; m_isdiv = 0;
      m_a = 0; m_b = 0; m_wdest = 0; m_wdata = 0;
      clear_stim(); clear_log();
      @(posedge clock); #1;
      s_reset = 1;
      repeat (2) cycle();
      s_reset = 0; s_rs = 5'd30;
      do_check = 1;
      cycle();
      chk("rst_busy", busy, 0);
      chk("rst_ctrl_mult", md_ctrl_mult, 0);
      chk("rst_ctrl_div", md_ctrl_div, 0);
      chk("rst_operandA", md_operandA, 0);
      chk("rst_operandB", md_operandB, 0);
      chk("rst_stall", stall, 0);
      s_rs = 0;

      // Mult 6x7 -> r3, free write port
      clear_log(); emu_lat = 1;
      issue_op(0, 5'd3, 32'd6, 32'd7);
      repeat (6) cycle();
      chk("mul_pulses", pulse_cnt, 1);
      chk("mul_nwrites", wlog_reg.size(), 1);
      if (wlog_reg.size() == 1) begin
         chk("mul_reg", wlog_reg[0], 3);
         chk("mul_data", wlog_data[0], 42);
         chk("mul_latency", wlog_cyc[0] - emu_rdy_cyc, 1);
      end
      chk("mul_idle", busy, 0);

      // Div 100/4 -> r5 while the pipeline owns the port for 3 cycles
      clear_log(); emu_lat = 0;
      issue_op(1, 5'd5, 32'd100, 32'd4);
      repeat (2) cycle();
      s_mwe = 1; s_mrd = 5'd8; s_mdata = 32'd9;
      repeat (3) cycle();
      s_mwe = 0;
      repeat (2) cycle();
      chk("div_nwrites", wlog_reg.size(), 4);
      if (wlog_reg.size() == 4) begin
         for (int i = 0; i < 3; i++) begin
            chk("div_mw_reg", wlog_reg[i], 8);
            chk("div_mw_data", wlog_data[i], 9);
         end
         chk("div_reg", wlog_reg[3], 5);
         chk("div_data", wlog_data[3], 25);
      end

      // Divide by zero and mult overflow both report through RSTATUS
      clear_log();
      issue_op(1, 5'd5, 32'd77, 32'd0);
      repeat (4) cycle();
      issue_op(0, 5'd7, 32'h10000, 32'h10000);
      repeat (4) cycle();
      chk("exc_nwrites", wlog_reg.size(), 2);
      if (wlog_reg.size() == 2) begin
         chk("divz_reg", wlog_reg[0], 30);
         chk("divz_data", wlog_data[0], 5);
         chk("ovf_reg", wlog_reg[1], 30);
         chk("ovf_data", wlog_data[1], 4);
      end

      // RAW on r3 stalls until the r3 write cycle
      clear_log(); emu_lat = 2;
      issue_op(0, 5'd3, 32'd3, 32'd3);
      s_rs = 5'd3;
      found = 0; prev_stall = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         prev_stall = obs_stall;
         cycle();
         if (wlog_reg.size() > 0 && wlog_reg[$] == 5'd3) found = 1;
      end
      chk("raw_write_seen", found, 1);
      chk("raw_stall_before", prev_stall, 1);
      chk("raw_stall_at_write", obs_stall, 0);
      s_rs = 0;
      // Unrelated registers do not stall
      issue_op(0, 5'd3, 32'd2, 32'd2);
      s_rs = 5'd4; s_drd = 5'd6; s_dwe = 1;
      cycle();
      chk("nohaz_busy", busy, 1);
      chk("nohaz_stall", obs_stall, 0);
      s_rs = 0; s_drd = 0; s_dwe = 0;
      repeat (6) cycle();

      // Structural hazard: second mult waits, launches after first drains
      clear_log(); emu_lat = 3;
      issue_op(0, 5'd3, 32'd2, 32'd5);
      s_mult = 1; s_rd = 5'd4; s_a = 32'd3; s_b = 32'd3;
      cycle();
      chk("struct_stall", obs_stall, 1);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (wlog_reg.size() > 0 && wlog_reg[$] == 5'd3) found = 1;
      end
      chk("struct_drain_seen", found, 1);
      s_mult = 0;
      cycle();
      chk("struct_second_pulse", obs_pulse, 1);
      // Reset while RUN; the late result must be dropped
      clear_log();
      s_reset = 1; cycle(); s_reset = 0;
      repeat (8) cycle();
      chk("rst_run_nwrites", wlog_reg.size(), 0);
      chk("rst_run_busy", busy, 0);

      // Randomized traffic
      emu_lat = -1;
      for (int i = 0; i < 3000; i++) begin
         int r = $urandom_range(0, 99);
         s_mult = (r < 15); s_div = (r >= 15 && r < 28);
         s_rd = pick_reg();
         s_a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1000);
         s_b = ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(0, 12);
         s_rs = pick_reg(); s_rt = pick_reg(); s_drd = pick_reg();
         s_dwe = 1'($urandom_range(0, 1));
         s_mwe = ($urandom_range(0, 9) < 4);
         s_mrd = 5'($urandom_range(0, 31)); s_mdata = $urandom;
         s_spur = ($urandom_range(0, 19) == 0);
         s_reset = ($urandom_range(0, 149) == 0);
         if (s_reset) s_mwe = 0;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
